// File: rtl/alu_arbiter.sv
// alu_arbiter
// Two-requester arbiter and issue sequencer for the shared 32-bit ALU.
// Port 0 is the integer execute path and port 1 is the address/branch-compare
// path. One request is granted per cycle and registered into the ALU inputs.
// The combinational ALU result is captured one cycle later and returned to
// the owning port as a single-cycle pulse.
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins contention
//                          undefined -> round-robin on a 1-bit last_grant
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   flush                      synchronous discard of all in-flight operations
//   req0_*/req1_*              valid/ready request handshakes with op, funct7, a, b
//   rsp0_valid, rsp1_valid     one-cycle result pulses per port
//   rsp_data                   shared result, qualified by rspN_valid
//   alu_op/alu_funct7/alu_a/alu_b  registered drive to the ALU
//   alu_data                   combinational ALU result

module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_op,
  input  logic             req0_funct7,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_op,
  input  logic             req1_funct7,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic [2:0]       alu_op,
  output logic             alu_funct7,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_data
);

  logic             gnt0;
  logic             gnt1;
  logic             any_gnt;

  logic             issue_valid;
  logic             issue_owner;
  logic [2:0]       issue_op;
  logic             issue_funct7;
  logic [WIDTH-1:0] issue_a;
  logic [WIDTH-1:0] issue_b;

  logic             result_valid;
  logic             result_owner;
  logic [WIDTH-1:0] result_data;

`ifdef ALU_ARB_FIXED_PRIO_EN
  // Port 1 only gets the ALU when port 0 has nothing to issue.
  always_comb begin
    gnt0 = req0_valid && !flush;
    gnt1 = req1_valid && !req0_valid && !flush;
  end
`else
  // last_grant remembers the most recent winner; under contention the other
  // port wins. It resets to 1 so port 0 takes the first contention.
  logic last_grant;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!flush) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1;
    end
  end
`endif

  assign any_gnt    = gnt0 || gnt1;
  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Issue stage: valid follows the grant every cycle, while the payload is
  // only reloaded on a grant so the ALU inputs stay quiet between operations.
  // Flush already suppresses the grant, which also clears the valid here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_valid  <= 1'b0;
      issue_owner  <= 1'b0;
      issue_op     <= 3'd0;
      issue_funct7 <= 1'b0;
      issue_a      <= '0;
      issue_b      <= '0;
    end else begin
      issue_valid <= any_gnt;
      if (any_gnt) begin
        issue_owner  <= gnt1;
        issue_op     <= gnt1 ? req1_op     : req0_op;
        issue_funct7 <= gnt1 ? req1_funct7 : req0_funct7;
        issue_a      <= gnt1 ? req1_a      : req0_a;
        issue_b      <= gnt1 ? req1_b      : req0_b;
      end
    end
  end

  // Result stage: capture the ALU output for the operation sitting in the
  // issue register, unless a flush discards it at this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      result_owner <= 1'b0;
      result_data  <= '0;
    end else begin
      result_valid <= issue_valid && !flush;
      if (issue_valid && !flush) begin
        result_owner <= issue_owner;
        result_data  <= alu_data;
      end
    end
  end

  assign alu_op     = issue_op;
  assign alu_funct7 = issue_funct7;
  assign alu_a      = issue_a;
  assign alu_b      = issue_b;

  assign rsp0_valid = result_valid && !result_owner;
  assign rsp1_valid = result_valid &&  result_owner;
  assign rsp_data   = result_data;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic        req0_funct7, req1_funct7;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp_data;
  logic [2:0]  alu_op;
  logic        alu_funct7;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state: who won last, the last granted payload (which the
  // ALU drive must show), and the responses still owed with their due edge.
  int          rr_last = 1;
  logic [2:0]  exp_op  = 3'd0;
  logic        exp_f7  = 1'b0;
  logic [31:0] exp_a   = 32'd0;
  logic [31:0] exp_b   = 32'd0;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } rsp_t;
  rsp_t pend_q[$];

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_funct7(req0_funct7), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_funct7(req1_funct7), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data),
    .alu_op(alu_op), .alu_funct7(alu_funct7), .alu_a(alu_a), .alu_b(alu_b),
    .alu_data(alu_data)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the shared ALU (RV32 funct3 encoding).
  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic f7,
                                         input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return f7 ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011:  return (a < b) ? 32'd1 : 32'd0;
      3'b100:  return a ^ b;
      3'b101:  return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_data = alu_fn(alu_op, alu_funct7, alu_a, alu_b);

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive requests after the falling edge, check readies
  // against the model's grant, step the model at the rising edge, then check
  // response pulses and ALU drive at the next falling edge.
  task automatic applyStimulus(
    input  logic v0, input logic [2:0] op0, input logic f0, input logic [31:0] a0, input logic [31:0] b0,
    input  logic v1, input logic [2:0] op1, input logic f1, input logic [31:0] a1, input logic [31:0] b1,
    input  logic fl, output logic g0, output logic g1, output logic r0, output logic r1);
    rsp_t        ent;
    logic        ev0, ev1;
    logic [31:0] ed;
    req0_valid = v0; req0_op = op0; req0_funct7 = f0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_funct7 = f1; req1_a = a1; req1_b = b1;
    flush = fl;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!fl) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
`else
      if (v0 && v1) begin
        if (rr_last == 1) g0 = 1'b1;
        else g1 = 1'b1;
      end else begin
        g0 = v0;
        g1 = v1;
      end
`endif
    end
    #1;
    r0 = req0_ready;
    r1 = req1_ready;
    checkOutput("req0_ready", 32'(r0), 32'(g0));
    checkOutput("req1_ready", 32'(r1), 32'(g1));
    @(posedge clk);
    cyc++;
    if (fl) begin
      for (int i = pend_q.size() - 1; i >= 0; i--)
        if (pend_q[i].due >= cyc) pend_q.delete(i);
    end
    if (g0 || g1) begin
      rr_last  = g1 ? 1 : 0;
      ent.port = g1 ? 1 : 0;
      ent.data = g1 ? alu_fn(op1, f1, a1, b1) : alu_fn(op0, f0, a0, b0);
      ent.due  = cyc + 1;
      pend_q.push_back(ent);
      exp_op = g1 ? op1 : op0;
      exp_f7 = g1 ? f1  : f0;
      exp_a  = g1 ? a1  : a0;
      exp_b  = g1 ? b1  : b0;
    end
    @(negedge clk);
    ev0 = 1'b0;
    ev1 = 1'b0;
    ed  = 32'd0;
    if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
      ent = pend_q.pop_front();
      ev0 = (ent.port == 0);
      ev1 = (ent.port == 1);
      ed  = ent.data;
    end
    checkOutput("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    checkOutput("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    if (ev0 || ev1) checkOutput("rsp_data", rsp_data, ed);
    checkOutput("alu_op", 32'(alu_op), 32'(exp_op));
    checkOutput("alu_funct7", 32'(alu_funct7), 32'(exp_f7));
    checkOutput("alu_a", alu_a, exp_a);
    checkOutput("alu_b", alu_b, exp_b);
  endtask

  task automatic idleCycle();
    logic g0, g1, r0, r1;
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, g0, g1, r0, r1);
  endtask

  initial begin
    logic        g0, g1, r0, r1;
    logic        p0, p1, fl;
    logic [2:0]  o0, o1;
    logic        ff0, ff1;
    logic [31:0] x0, y0, x1, y1;

    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b0; req0_op = 3'd0; req0_funct7 = 1'b0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 3'd0; req1_funct7 = 1'b0; req1_a = 32'd0; req1_b = 32'd0;
    repeat (2) @(negedge clk);
    $display("[TB] reset values");
    checkOutput("reset_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("reset_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("reset_rsp_data", rsp_data, 32'd0);
    checkOutput("reset_alu_op", 32'(alu_op), 32'd0);
    checkOutput("reset_alu_funct7", 32'(alu_funct7), 32'd0);
    checkOutput("reset_alu_a", alu_a, 32'd0);
    checkOutput("reset_alu_b", alu_b, 32'd0);
    checkOutput("reset_ready0", 32'(req0_ready), 32'd0);
    rst = 1'b0;

    $display("[TB] ADD on port 0");
    applyStimulus(1'b1, 3'b000, 1'b0, 32'd5, 32'd3, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, g0, g1, r0, r1);
    checkOutput("add_ready0", 32'(r0), 32'd1);
    idleCycle();
    checkOutput("add_rsp0_valid", 32'(rsp0_valid), 32'd1);
    checkOutput("add_rsp_data", rsp_data, 32'd8);
    checkOutput("add_rsp1_valid", 32'(rsp1_valid), 32'd0);
    idleCycle();

    $display("[TB] SUB on port 1");
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 3'b000, 1'b1, 32'd5, 32'd7, 1'b0, g0, g1, r0, r1);
    checkOutput("sub_ready1", 32'(r1), 32'd1);
    idleCycle();
    checkOutput("sub_rsp1_valid", 32'(rsp1_valid), 32'd1);
    checkOutput("sub_rsp_data", rsp_data, 32'hFFFF_FFFE);
    checkOutput("sub_rsp0_valid", 32'(rsp0_valid), 32'd0);
    idleCycle();

    $display("[TB] contention");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 3'b100, 1'b0, 32'hF0, 32'h0F, 1'b1, 3'b111, 1'b0, 32'hF0, 32'h3C, 1'b0, g0, g1, r0, r1);
`ifdef ALU_ARB_FIXED_PRIO_EN
      checkOutput("contend_ready0", 32'(r0), 32'd1);
`else
      checkOutput("contend_ready0", 32'(r0), (k % 2 == 0) ? 32'd1 : 32'd0);
      if (k == 1) checkOutput("contend_rsp0", rsp_data, 32'hFF);
      if (k == 2) checkOutput("contend_rsp1", rsp_data, 32'h30);
      if (k == 3) checkOutput("contend_rsp0b", rsp_data, 32'hFF);
`endif
    end
    idleCycle();
`ifndef ALU_ARB_FIXED_PRIO_EN
    checkOutput("contend_last_rsp1", 32'(rsp1_valid), 32'd1);
    checkOutput("contend_last_data", rsp_data, 32'h30);
`endif
    idleCycle();

`ifdef ALU_ARB_FIXED_PRIO_EN
    $display("[TB] fixed priority");
    for (int k = 0; k < 4; k++) begin
      applyStimulus(k < 3, 3'b000, 1'b0, 32'd1, 32'd2, 1'b1, 3'b110, 1'b0, 32'd8, 32'd1, 1'b0, g0, g1, r0, r1);
      checkOutput("fixed_ready1", 32'(r1), (k == 3) ? 32'd1 : 32'd0);
    end
    idleCycle();
    idleCycle();
`endif

    $display("[TB] flush");
    applyStimulus(1'b1, 3'b001, 1'b0, 32'd1, 32'd4, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, g0, g1, r0, r1);
    checkOutput("flush_accept0", 32'(r0), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 1'b1, g0, g1, r0, r1);
    checkOutput("flush_ready1", 32'(r1), 32'd0);
    checkOutput("flush_no_rsp0", 32'(rsp0_valid), 32'd0);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 1'b0, g0, g1, r0, r1);
    checkOutput("flush_after_ready1", 32'(r1), 32'd1);
    idleCycle();
    checkOutput("flush_after_rsp", rsp_data, 32'h33);
    idleCycle();

    $display("[TB] reset mid-flight");
    applyStimulus(1'b1, 3'b110, 1'b0, 32'hF0, 32'h0F, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b0, g0, g1, r0, r1);
    rst = 1'b1;
    #1;
    checkOutput("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    checkOutput("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    checkOutput("rst_alu_op", 32'(alu_op), 32'd0);
    checkOutput("rst_alu_a", alu_a, 32'd0);
    checkOutput("rst_alu_b", alu_b, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_no_pulse", 32'(rsp0_valid), 32'd0);
    pend_q.delete();
    rr_last = 1;
    exp_op = 3'd0; exp_f7 = 1'b0; exp_a = 32'd0; exp_b = 32'd0;
    rst = 1'b0;
    applyStimulus(1'b1, 3'b000, 1'b0, 32'd9, 32'd1, 1'b1, 3'b000, 1'b0, 32'd2, 32'd2, 1'b0, g0, g1, r0, r1);
    checkOutput("rst_first_contention0", 32'(r0), 32'd1);
    applyStimulus(1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 1'b1, 3'b000, 1'b0, 32'd2, 32'd2, 1'b0, g0, g1, r0, r1);
    idleCycle();
    idleCycle();

    $display("[TB] randomized traffic");
    p0 = 1'b0; p1 = 1'b0;
    o0 = 3'd0; o1 = 3'd0; ff0 = 1'b0; ff1 = 1'b0;
    x0 = 32'd0; y0 = 32'd0; x1 = 32'd0; y1 = 32'd0;
    for (int n = 0; n < 400; n++) begin
      if (!p0 && $urandom_range(0, 99) < 60) begin
        p0 = 1'b1; o0 = 3'($urandom_range(0, 7)); ff0 = 1'($urandom_range(0, 1));
        x0 = $urandom; y0 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      end
      if (!p1 && $urandom_range(0, 99) < 60) begin
        p1 = 1'b1; o1 = 3'($urandom_range(0, 7)); ff1 = 1'($urandom_range(0, 1));
        x1 = $urandom; y1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      end
      fl = ($urandom_range(0, 99) < 6);
      applyStimulus(p0, o0, ff0, x0, y0, p1, o1, ff1, x1, y1, fl, g0, g1, r0, r1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
    repeat (3) idleCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
